ift_sr_reg: RTL and testbench



---
 rtl/ift_sr_reg.sv | 139 +++++++++++++
 tb/tb_ift_sr_reg.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ift_sr_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ift_sr_reg
//  Purpose  : WIDTH-bit set/clear flag register with information-flow
//             tracking. Each bit has its own SET/CLR request, and either clear
//             or set dominance can be selected. The register also carries a
//             TAINT_W-bit label, combined by bitwise OR, that records which
//             controls (SET/CLR/EN/SRST) could have influenced the stored
//             value. The label is scrubbed when the old contents can no
//             longer matter.
//  Optional : define IFT_SR_TAINT_AGE_EN to add the Q_age taint-age counter.
//  Ports    :
//    CLK            in   clock, rising edge
//    SRST           in   synchronous reset, active-high
//    SRST_t         in   label of SRST
//    EN             in   update enable
//    EN_t           in   label of EN
//    SET  [WIDTH]   in   per-bit set request
//    SET_t          in   label of SET
//    CLR  [WIDTH]   in   per-bit clear request
//    CLR_t          in   label of CLR
//    Q    [WIDTH]   out  registered flag state
//    Q_t            out  registered label of Q
//    Q_age[AGE_W]   out  consecutive cycles with non-zero label, saturating
//                        (IFT_SR_TAINT_AGE_EN only)
//  Revision : 1.0 - initial release
// ============================================================================
module ift_sr_reg #(
    parameter int unsigned      WIDTH    = 2,
    parameter int unsigned      TAINT_W  = 32,
    parameter bit               CLR_PRIO = 1'b1,
    parameter logic [WIDTH-1:0] INIT     = '0,
    parameter int unsigned      AGE_W    = 8
) (
    input  logic               CLK,
    input  logic               SRST,
    input  logic [TAINT_W-1:0] SRST_t,
    input  logic               EN,
    input  logic [TAINT_W-1:0] EN_t,
    input  logic [WIDTH-1:0]   SET,
    input  logic [TAINT_W-1:0] SET_t,
    input  logic [WIDTH-1:0]   CLR,
    input  logic [TAINT_W-1:0] CLR_t,
    output logic [WIDTH-1:0]   Q,
    output logic [TAINT_W-1:0] Q_t
`ifdef IFT_SR_TAINT_AGE_EN
    ,
    output logic [AGE_W-1:0]   Q_age
`endif
);

    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   q_d;
    logic [TAINT_W-1:0] qt_q;
    logic [TAINT_W-1:0] qt_d;

    // Label-relevance terms for an enabled update:
    //   w_sm - some bit can actually take its value from SET
    //   w_cm - some bit can actually take its value from CLR
    //   w_hm - some bit keeps its old value, so the old label survives
    // A dominated control only leaks its label where it is not masked.
    logic w_sm;
    logic w_cm;
    logic w_hm;

    always_comb begin
        w_hm = |(~SET & ~CLR);
        if (CLR_PRIO) begin
            w_sm = |(~CLR);
            w_cm = 1'b1;
        end else begin
            w_sm = 1'b1;
            w_cm = |(~SET);
        end
    end

    always_comb begin
        q_d  = q_q;
        qt_d = qt_q | EN_t;
        if (EN) begin
            if (CLR_PRIO) begin
                q_d = (q_q | SET) & ~CLR;
            end else begin
                q_d = (q_q & ~CLR) | SET;
            end
            qt_d = EN_t
                 | ({TAINT_W{w_sm}} & SET_t)
                 | ({TAINT_W{w_cm}} & CLR_t)
                 | ({TAINT_W{w_hm}} & qt_q);
        end
    end

    // Reset is itself a flow: its label replaces whatever was held.
    always_ff @(posedge CLK) begin
        if (SRST) begin
            q_q  <= INIT;
            qt_q <= SRST_t;
        end else begin
            q_q  <= q_d;
            qt_q <= qt_d;
        end
    end

    assign Q   = q_q;
    assign Q_t = qt_q;

`ifdef IFT_SR_TAINT_AGE_EN
    localparam logic [AGE_W-1:0] c_AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;

    // The age follows the label that is being written on this edge, so a
    // scrub and an age of zero appear together.
    always_comb begin
        age_d = age_q;
        if (qt_d == '0) begin
            age_d = '0;
        end else if (!(&age_q)) begin
            age_d = age_q + c_AGE_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign Q_age = age_q;
`else
    logic [AGE_W-1:0] w_unused_age;
    assign w_unused_age = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ift_sr_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ift_sr_reg
//  Purpose  : Self-checking bench for ift_sr_reg. Two instances share one
//             stimulus: A is clear-dominant with INIT=00, B is set-dominant
//             with INIT=10. Expected results are queued when stimulus is
//             driven and popped once the edge has been taken.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ift_sr_reg;

    localparam int W  = 2;
    localparam int TW = 32;
    localparam int AW = 2;
    localparam logic [W-1:0] INIT_B = 2'b10;

    logic          CLK = 1'b0;
    logic          SRST;
    logic [TW-1:0] SRST_t;
    logic          EN;
    logic [TW-1:0] EN_t;
    logic [W-1:0]  SET;
    logic [TW-1:0] SET_t;
    logic [W-1:0]  CLR;
    logic [TW-1:0] CLR_t;
    logic [W-1:0]  q_a;
    logic [W-1:0]  q_b;
    logic [TW-1:0] qt_a;
    logic [TW-1:0] qt_b;
`ifdef IFT_SR_TAINT_AGE_EN
    logic [AW-1:0] age_a;
    logic [AW-1:0] age_b;
`endif

    always #5 CLK = ~CLK;

    ift_sr_reg #(.WIDTH(W), .TAINT_W(TW), .CLR_PRIO(1'b1), .INIT(2'b00), .AGE_W(AW)) u_dut_a (
        .CLK(CLK), .SRST(SRST), .SRST_t(SRST_t), .EN(EN), .EN_t(EN_t),
        .SET(SET), .SET_t(SET_t), .CLR(CLR), .CLR_t(CLR_t),
        .Q(q_a), .Q_t(qt_a)
`ifdef IFT_SR_TAINT_AGE_EN
        , .Q_age(age_a)
`endif
    );

    ift_sr_reg #(.WIDTH(W), .TAINT_W(TW), .CLR_PRIO(1'b0), .INIT(INIT_B), .AGE_W(AW)) u_dut_b (
        .CLK(CLK), .SRST(SRST), .SRST_t(SRST_t), .EN(EN), .EN_t(EN_t),
        .SET(SET), .SET_t(SET_t), .CLR(CLR), .CLR_t(CLR_t),
        .Q(q_b), .Q_t(qt_b)
`ifdef IFT_SR_TAINT_AGE_EN
        , .Q_age(age_b)
`endif
    );

    typedef struct {
        logic          srst;
        logic [TW-1:0] srst_t;
        logic          en;
        logic [TW-1:0] en_t;
        logic [W-1:0]  set;
        logic [TW-1:0] set_t;
        logic [W-1:0]  clr;
        logic [TW-1:0] clr_t;
    } stim_t;

    typedef struct {
        logic [W-1:0]  q_a;
        logic [TW-1:0] t_a;
        logic [W-1:0]  q_b;
        logic [TW-1:0] t_b;
        logic [AW-1:0] age_a;
        logic [AW-1:0] age_b;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic apply(input stim_t s);
        SRST   = s.srst;
        SRST_t = s.srst_t;
        EN     = s.en;
        EN_t   = s.en_t;
        SET    = s.set;
        SET_t  = s.set_t;
        CLR    = s.clr;
        CLR_t  = s.clr_t;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Independent per-bit reference for one instance.
    function automatic void model_next(input bit prio, input logic [W-1:0] init,
                                       input stim_t s,
                                       inout logic [W-1:0] q, inout logic [TW-1:0] t,
                                       inout logic [AW-1:0] age);
        logic [W-1:0]  nq;
        logic [TW-1:0] nt;
        bit set_live;
        bit clr_live;
        bit hold_any;
        if (s.srst) begin
            q   = init;
            t   = s.srst_t;
            age = '0;
            return;
        end
        nq       = q;
        nt       = s.en_t;
        set_live = !prio;
        clr_live = prio;
        hold_any = 1'b0;
        if (!s.en) begin
            nt = nt | t;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (!s.set[i] && !s.clr[i]) hold_any = 1'b1;
                if (prio) begin
                    if (!s.clr[i]) set_live = 1'b1;
                    if (s.clr[i]) nq[i] = 1'b0;
                    else if (s.set[i]) nq[i] = 1'b1;
                end else begin
                    if (!s.set[i]) clr_live = 1'b1;
                    if (s.set[i]) nq[i] = 1'b1;
                    else if (s.clr[i]) nq[i] = 1'b0;
                end
            end
            if (set_live) nt = nt | s.set_t;
            if (clr_live) nt = nt | s.clr_t;
            if (hold_any) nt = nt | t;
        end
        if (nt == '0) age = '0;
        else if (age != 2'd3) age = age + 2'd1;
        q = nq;
        t = nt;
    endfunction

    function automatic logic [TW-1:0] rnd_label();
        case ($urandom_range(0, 3))
            0:       return '0;
            1, 2:    return 32'h1 << $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    // Plan item 1: reset wins over EN/SET, label comes from SRST_t, then held.
    task automatic test_reset();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  got;
        st[0] = '{1'b1, 32'h10, 1'b1, 32'h0, 2'b11, 32'h0, 2'b00, 32'h0};
        ex[0] = '{2'b00, 32'h10, INIT_B, 32'h10, 2'd0, 2'd0};
        st[1] = '{1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 32'h0, 2'b00, 32'h0};
        ex[1] = '{2'b00, 32'h10, INIT_B, 32'h10, 2'd0, 2'd0};
        for (int i = 0; i < 2; i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            got = sb.pop_front();
            checks += 4;
            if (q_a !== got.q_a) begin errors++; $display("FAIL reset[%0d] A.Q got=%h exp=%h", i, q_a, got.q_a); end
            if (qt_a !== got.t_a) begin errors++; $display("FAIL reset[%0d] A.Q_t got=%h exp=%h", i, qt_a, got.t_a); end
            if (q_b !== got.q_b) begin errors++; $display("FAIL reset[%0d] B.Q got=%h exp=%h", i, q_b, got.q_b); end
            if (qt_b !== got.t_b) begin errors++; $display("FAIL reset[%0d] B.Q_t got=%h exp=%h", i, qt_b, got.t_b); end
        end
    endtask

    // Plan items 2 and 3: enabled update, then full overwrite with scrub.
    task automatic test_update();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  got;
        st[0] = '{1'b1, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0};
        ex[0] = '{2'b00, 32'h0, INIT_B, 32'h0, 2'd0, 2'd0};
        st[1] = '{1'b0, 32'h0, 1'b1, 32'h0, 2'b01, 32'h1, 2'b00, 32'h2};
        ex[1] = '{2'b01, 32'h3, 2'b11, 32'h3, 2'd0, 2'd0};
        st[2] = '{1'b0, 32'h0, 1'b1, 32'h0, 2'b11, 32'h4, 2'b11, 32'h0};
        ex[2] = '{2'b00, 32'h0, 2'b11, 32'h4, 2'd0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            got = sb.pop_front();
            checks += 4;
            if (q_a !== got.q_a) begin errors++; $display("FAIL update[%0d] A.Q got=%h exp=%h", i, q_a, got.q_a); end
            if (qt_a !== got.t_a) begin errors++; $display("FAIL update[%0d] A.Q_t got=%h exp=%h", i, qt_a, got.t_a); end
            if (q_b !== got.q_b) begin errors++; $display("FAIL update[%0d] B.Q got=%h exp=%h", i, q_b, got.q_b); end
            if (qt_b !== got.t_b) begin errors++; $display("FAIL update[%0d] B.Q_t got=%h exp=%h", i, qt_b, got.t_b); end
        end
    endtask

    // Plan item 4: EN=0 holds data but the EN label still accumulates.
    task automatic test_hold();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  got;
        st[0] = '{1'b1, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0};
        ex[0] = '{2'b00, 32'h0, INIT_B, 32'h0, 2'd0, 2'd0};
        st[1] = '{1'b0, 32'h0, 1'b1, 32'h0, 2'b01, 32'h1, 2'b00, 32'h2};
        ex[1] = '{2'b01, 32'h3, 2'b11, 32'h3, 2'd0, 2'd0};
        st[2] = '{1'b0, 32'h0, 1'b0, 32'h8, 2'b11, 32'h40, 2'b00, 32'h80};
        ex[2] = '{2'b01, 32'hB, 2'b11, 32'hB, 2'd0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            got = sb.pop_front();
            checks += 4;
            if (q_a !== got.q_a) begin errors++; $display("FAIL hold[%0d] A.Q got=%h exp=%h", i, q_a, got.q_a); end
            if (qt_a !== got.t_a) begin errors++; $display("FAIL hold[%0d] A.Q_t got=%h exp=%h", i, qt_a, got.t_a); end
            if (q_b !== got.q_b) begin errors++; $display("FAIL hold[%0d] B.Q got=%h exp=%h", i, q_b, got.q_b); end
            if (qt_b !== got.t_b) begin errors++; $display("FAIL hold[%0d] B.Q_t got=%h exp=%h", i, qt_b, got.t_b); end
        end
    endtask

    // Plan item 5: simultaneous SET/CLR resolved by priority in each instance.
    task automatic test_priority();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  got;
        st[0] = '{1'b1, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0};
        ex[0] = '{2'b00, 32'h0, INIT_B, 32'h0, 2'd0, 2'd0};
        st[1] = '{1'b0, 32'h0, 1'b1, 32'h0, 2'b11, 32'h1, 2'b11, 32'h2};
        ex[1] = '{2'b00, 32'h2, 2'b11, 32'h1, 2'd0, 2'd0};
        st[2] = '{1'b0, 32'h0, 1'b1, 32'h0, 2'b00, 32'h1, 2'b10, 32'h2};
        ex[2] = '{2'b00, 32'h3, 2'b01, 32'h3, 2'd0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            got = sb.pop_front();
            checks += 4;
            if (q_a !== got.q_a) begin errors++; $display("FAIL prio[%0d] A.Q got=%h exp=%h", i, q_a, got.q_a); end
            if (qt_a !== got.t_a) begin errors++; $display("FAIL prio[%0d] A.Q_t got=%h exp=%h", i, qt_a, got.t_a); end
            if (q_b !== got.q_b) begin errors++; $display("FAIL prio[%0d] B.Q got=%h exp=%h", i, q_b, got.q_b); end
            if (qt_b !== got.t_b) begin errors++; $display("FAIL prio[%0d] B.Q_t got=%h exp=%h", i, qt_b, got.t_b); end
        end
    endtask

`ifdef IFT_SR_TAINT_AGE_EN
    // Plan item 6: age saturates at 3 and clears on the scrubbing edge;
    // reset clears the age even when the reset label is non-zero.
    task automatic test_age();
        stim_t st[8];
        exp_t  ex[8];
        exp_t  got;
        st[0] = '{1'b1, 32'h4, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0};
        ex[0] = '{2'b00, 32'h4, INIT_B, 32'h4, 2'd0, 2'd0};
        st[1] = '{1'b1, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0};
        ex[1] = '{2'b00, 32'h0, INIT_B, 32'h0, 2'd0, 2'd0};
        for (int k = 0; k < 5; k++) begin
            st[2+k] = '{1'b0, 32'h0, 1'b0, 32'h1, 2'b00, 32'h0, 2'b00, 32'h0};
            ex[2+k] = '{2'b00, 32'h1, INIT_B, 32'h1, 2'd0, 2'd0};
        end
        ex[2].age_a = 2'd1; ex[2].age_b = 2'd1;
        ex[3].age_a = 2'd2; ex[3].age_b = 2'd2;
        for (int k = 4; k < 7; k++) begin
            ex[k].age_a = 2'd3;
            ex[k].age_b = 2'd3;
        end
        st[7] = '{1'b0, 32'h0, 1'b1, 32'h0, 2'b00, 32'h0, 2'b11, 32'h0};
        ex[7] = '{2'b00, 32'h0, 2'b00, 32'h0, 2'd0, 2'd0};
        for (int i = 0; i < 8; i++) begin
            apply(st[i]);
            sb.push_back(ex[i]);
            tick();
            got = sb.pop_front();
            checks += 4;
            if (qt_a !== got.t_a) begin errors++; $display("FAIL age[%0d] A.Q_t got=%h exp=%h", i, qt_a, got.t_a); end
            if (qt_b !== got.t_b) begin errors++; $display("FAIL age[%0d] B.Q_t got=%h exp=%h", i, qt_b, got.t_b); end
            if (age_a !== got.age_a) begin errors++; $display("FAIL age[%0d] A.Q_age got=%0d exp=%0d", i, age_a, got.age_a); end
            if (age_b !== got.age_b) begin errors++; $display("FAIL age[%0d] B.Q_age got=%0d exp=%0d", i, age_b, got.age_b); end
        end
    endtask
`endif

    // Random traffic against the reference model, including mid-run resets.
    task automatic test_random();
        logic [W-1:0]  mq_a = '0;
        logic [W-1:0]  mq_b = '0;
        logic [TW-1:0] mt_a = '0;
        logic [TW-1:0] mt_b = '0;
        logic [AW-1:0] mg_a = '0;
        logic [AW-1:0] mg_b = '0;
        stim_t s;
        exp_t  e;
        exp_t  got;
        for (int i = 0; i < 300; i++) begin
            s.srst   = (i == 0) || ($urandom_range(0, 19) == 0);
            s.srst_t = rnd_label();
            s.en     = ($urandom_range(0, 3) != 0);
            s.en_t   = ($urandom_range(0, 1) == 0) ? '0 : rnd_label();
            s.set    = W'($urandom_range(0, 3));
            s.set_t  = rnd_label();
            s.clr    = W'($urandom_range(0, 3));
            s.clr_t  = rnd_label();
            model_next(1'b1, 2'b00, s, mq_a, mt_a, mg_a);
            model_next(1'b0, INIT_B, s, mq_b, mt_b, mg_b);
            e = '{mq_a, mt_a, mq_b, mt_b, mg_a, mg_b};
            apply(s);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            checks += 4;
            if (q_a !== got.q_a) begin errors++; $display("FAIL rand[%0d] A.Q got=%h exp=%h", i, q_a, got.q_a); end
            if (qt_a !== got.t_a) begin errors++; $display("FAIL rand[%0d] A.Q_t got=%h exp=%h", i, qt_a, got.t_a); end
            if (q_b !== got.q_b) begin errors++; $display("FAIL rand[%0d] B.Q got=%h exp=%h", i, q_b, got.q_b); end
            if (qt_b !== got.t_b) begin errors++; $display("FAIL rand[%0d] B.Q_t got=%h exp=%h", i, qt_b, got.t_b); end
`ifdef IFT_SR_TAINT_AGE_EN
            checks += 2;
            if (age_a !== got.age_a) begin errors++; $display("FAIL rand[%0d] A.Q_age got=%0d exp=%0d", i, age_a, got.age_a); end
            if (age_b !== got.age_b) begin errors++; $display("FAIL rand[%0d] B.Q_age got=%0d exp=%0d", i, age_b, got.age_b); end
`endif
        end
    endtask

    initial begin
        apply('{1'b1, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0});
        test_reset();
        test_update();
        test_hold();
        test_priority();
`ifdef IFT_SR_TAINT_AGE_EN
        test_age();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time=%0t limit=100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
